// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler that shares one W-bit up-counter
// between NREQ requesters. The winner's terminal count is latched, the
// counter runs 0..tc, and a one-cycle done pulse is tagged with the
// winner's index.
//
// Optional feature: define COUNTER_SCHED_PAUSE_EN to add a 'pause' input.
// While in RUN, pause=1 freezes the count and the end-of-run check.
//
// Handshake: req[i] is a level request. Requester i raises it and keeps it
// high until it sees done=1 with done_id=i. The block samples req only in
// IDLE. Dropping req during a run does not cancel that run. grant is the
// registered one-hot owner of the counter and stays set through RUN and
// DONE.
module counter_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] tc_flat,
`ifdef COUNTER_SCHED_PAUSE_EN
  input  logic              pause,
`endif
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [W-1:0]      count,
  output logic              done,
  output logic [IDW-1:0]    done_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // state is kept as a named signal so checkers can bind to it.
  state_t          state, state_n;
  logic [IDW-1:0]  ptr, ptr_n;
  logic [IDW-1:0]  owner, owner_n;
  logic [W-1:0]    tc_q, tc_n;
  logic [W-1:0]    count_n;
  logic [NREQ-1:0] grant_n;
  logic            busy_n, done_n;
  logic [IDW-1:0]  done_id_n;

  logic            found;
  logic [IDW-1:0]  winner, cand;
  logic [W-1:0]    tc_sel;
  logic [NREQ-1:0] onehot_sel;
  logic            hold;

`ifdef COUNTER_SCHED_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Round-robin search: first set req bit strictly after the last winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int o = 1; o <= NREQ; o++) begin
      cand = IDW'((int'(ptr) + o) % NREQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Select the winner's terminal count and build its one-hot grant.
  always_comb begin
    tc_sel     = '0;
    onehot_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == winner) begin
        tc_sel        = tc_flat[i*W +: W];
        onehot_sel[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    tc_n      = tc_q;
    count_n   = count;
    grant_n   = grant;
    busy_n    = busy;
    done_n    = 1'b0;
    done_id_n = done_id;
    case (state)
      S_IDLE: begin
        count_n = '0;
        if (found) begin
          state_n = S_RUN;
          grant_n = onehot_sel;
          tc_n    = tc_sel;
          owner_n = winner;
          busy_n  = 1'b1;
        end
      end
      S_RUN: begin
        if (!hold) begin
          if (count == tc_q) begin
            // Run ends here; done rises as DONE is entered.
            state_n   = S_DONE;
            done_n    = 1'b1;
            done_id_n = owner;
          end else begin
            count_n = count + W'(1);
          end
        end
      end
      S_DONE: begin
        // Release the counter; the finished owner drops to lowest priority.
        state_n = S_IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
        ptr_n   = owner;
        count_n = '0;
      end
      default: begin
        state_n = S_IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
        count_n = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= IDW'(NREQ - 1);
      owner   <= '0;
      tc_q    <= '0;
      count   <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      tc_q    <= tc_n;
      count   <= count_n;
      grant   <= grant_n;
      busy    <= busy_n;
      done    <= done_n;
      done_id <= done_id_n;
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: self-checking bench for counter_sched. A transaction
// model predicts the round-robin winner and the cycle-by-cycle trace of
// {grant, busy, count, done, done_id} for each run.
module tb_counter_sched;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;
  localparam int TRW  = NREQ + 1 + W + 1 + IDW;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] tc_flat;
  logic              pause;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [W-1:0]      count;
  logic              done;
  logic [IDW-1:0]    done_id;

  logic [W-1:0]      tcs [NREQ];
  logic [TRW-1:0]    obs;
  logic [TRW-1:0]    exp_q[$];

  int                errors;
  int                checks;
  int                ptr_m;
  logic [IDW-1:0]    last_id_m;

  counter_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .tc_flat (tc_flat),
`ifdef COUNTER_SCHED_PAUSE_EN
    .pause   (pause),
`endif
    .grant   (grant),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .done_id (done_id)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign tc_flat[gi*W +: W] = tcs[gi];
  end

  assign obs = {grant, busy, count, done, done_id};

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int predict(input logic [NREQ-1:0] r, input int p);
    int k;
    predict = -1;
    for (int o = 1; o <= NREQ; o++) begin
      k = (p + o) % NREQ;
      if (predict < 0 && ((r >> k) & NREQ'(1)) != '0) predict = k;
    end
  endfunction

  // Expected trace of one run, starting with the sample after the grant
  // edge and ending with the sample back in idle. The count value p_at is
  // seen p_len extra times when pause is held there.
  task automatic model_run(input int win, input int tc, input int p_at, input int p_len);
    logic [NREQ-1:0] g;
    int reps;
    g = NREQ'(1) << win;
    for (int j = 0; j <= tc; j++) begin
      reps = (j == p_at) ? p_len + 1 : 1;
      for (int r = 0; r < reps; r++)
        exp_q.push_back({g, 1'b1, W'(j), 1'b0, last_id_m});
    end
    exp_q.push_back({g, 1'b1, W'(tc), 1'b1, IDW'(win)});
    exp_q.push_back({{NREQ{1'b0}}, 1'b0, {W{1'b0}}, 1'b0, IDW'(win)});
    last_id_m = IDW'(win);
    ptr_m     = win;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst       = 1'b0;
    ptr_m     = NREQ - 1;
    last_id_m = '0;
  endtask

  task automatic set_all_tc(input int v);
    for (int i = 0; i < NREQ; i++) tcs[i] = W'(v);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_idle s%0d: got %h expected %h", i, obs, {TRW{1'b0}});
      end
    end
    ptr_m     = NREQ - 1;
    last_id_m = '0;
  endtask

  task automatic test_single_run();
    logic [TRW-1:0] e;
    int i;
    set_all_tc(0);
    tcs[2] = W'(5);
    req = 4'b0100;
    model_run(predict(req, ptr_m), 5, -1, 0);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_run s%0d: got %h expected %h", i, obs, e);
      end
      if (exp_q.size() == 1) req = '0;
      i++;
    end
  endtask

  task automatic test_round_robin();
    logic [TRW-1:0] e;
    int i;
    req = '0;
    apply_reset(2);
    set_all_tc(1);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) model_run(predict(req, ptr_m), 1, -1, 0);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL round_robin s%0d: got %h expected %h", i, obs, e);
      end
      if (exp_q.size() == 1) req = '0;
      i++;
    end
  endtask

  task automatic test_boundaries();
    logic [TRW-1:0] e;
    int i;
    // tc = 0 on requester 3, then tc = all-ones on requester 0.
    for (int b = 0; b < 2; b++) begin
      set_all_tc(7);
      if (b == 0) begin
        tcs[3] = '0;
        req    = 4'b1000;
        model_run(predict(req, ptr_m), 0, -1, 0);
      end else begin
        tcs[0] = '1;
        req    = 4'b0001;
        model_run(predict(req, ptr_m), (1 << W) - 1, -1, 0);
      end
      i = 0;
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL boundary_tc%0d s%0d: got %h expected %h", b, i, obs, e);
        end
        if (exp_q.size() == 1) req = '0;
        i++;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [TRW-1:0] e;
    int i;
    set_all_tc(3);
    tcs[1] = W'(10);
    req = 4'b0010;
    model_run(predict(req, ptr_m), 10, -1, 0);
    // Follow the run up to count=4, then abort it with reset.
    for (i = 0; i < 5; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_run s%0d: got %h expected %h", i, obs, e);
      end
    end
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_mid_run abort: got %h expected %h", obs, {TRW{1'b0}});
    end
    ptr_m     = NREQ - 1;
    last_id_m = '0;
    model_run(predict(req, ptr_m), 10, -1, 0);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_run regrant s%0d: got %h expected %h", i, obs, e);
      end
      if (exp_q.size() == 1) req = '0;
      i++;
    end
  endtask

`ifdef COUNTER_SCHED_PAUSE_EN
  task automatic test_pause();
    logic [TRW-1:0] e;
    int i;
    set_all_tc(2);
    tcs[3] = W'(6);
    req   = 4'b1000;
    pause = 1'b1;  // held in idle: must not delay the grant
    model_run(predict(req, ptr_m), 6, 3, 3);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pause s%0d: got %h expected %h", i, obs, e);
      end
      pause = (i >= 3 && i <= 5);
      if (exp_q.size() == 1) req = '0;
      i++;
    end
    pause = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [TRW-1:0] e;
    int i;
    int w;
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < NREQ; k++) tcs[k] = W'($urandom_range(0, (1 << W) - 1));
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      w = predict(req, ptr_m);
      model_run(w, int'(tcs[IDW'(w)]), -1, 0);
      i = 0;
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL random r%0d s%0d: got %h expected %h", n, i, obs, e);
        end
        if (i == 0) begin
          // Latched tc and the ongoing run must ignore these changes.
          for (int k = 0; k < NREQ; k++) tcs[k] = W'($urandom_range(0, (1 << W) - 1));
          req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        end
        if (exp_q.size() == 1) req = '0;
        i++;
      end
    end
  endtask

  // Test sequence and final report.
  initial begin
    errors    = 0;
    checks    = 0;
    ptr_m     = NREQ - 1;
    last_id_m = '0;
    rst       = 1'b1;
    req       = '0;
    pause     = 1'b0;
    set_all_tc(0);
    test_reset();
    test_single_run();
    test_round_robin();
    test_boundaries();
    test_reset_mid_run();
`ifdef COUNTER_SCHED_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
